// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control sequencer: fetch/decode/execute/mem/write-back FSM.
// Latency: outputs decode combinationally from the state register (FETCH strobes gated by mem_ready).
// Backpressure: FETCH, MEM_READ and MEM_WRITE hold with requests stable until mem_ready.
module multicycle_ctrl #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [5:0]           instr_opcode,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 mem_to_reg,
  output logic                 reg_dst,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           pc_source,
  output logic                 illegal_op,
  output logic                 retired,
  output logic [WORD_SIZE-1:0] retire_count,
  output logic [3:0]           state_dbg
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_MEM_ADDR  = 4'd3;
  localparam logic [3:0] S_MEM_READ  = 4'd4;
  localparam logic [3:0] S_MEM_WB    = 4'd5;
  localparam logic [3:0] S_MEM_WRITE = 4'd6;
  localparam logic [3:0] S_EXECUTE   = 4'd7;
  localparam logic [3:0] S_ALU_WB    = 4'd8;
  localparam logic [3:0] S_BRANCH    = 4'd9;
  localparam logic [3:0] S_JUMP      = 4'd10;
  localparam logic [3:0] S_ADDI_EXEC = 4'd11;
  localparam logic [3:0] S_ADDI_WB   = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  logic [3:0]           r_state;
  logic [3:0]           w_next_state;
  logic                 w_instr_end;
  logic                 w_illegal;
  logic [WORD_SIZE-1:0] r_retire_count;

  // Next-state selection; every instruction end funnels through one run check.
  always_comb begin
    w_next_state = r_state;
    w_instr_end  = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_IDLE:      if (run) w_next_state = S_FETCH;
      S_FETCH:     if (mem_ready) w_next_state = S_DECODE;
      S_DECODE: begin
        case (instr_opcode)
          OP_RTYPE:    w_next_state = S_EXECUTE;
          OP_LW, OP_SW: w_next_state = S_MEM_ADDR;
          OP_BEQ:      w_next_state = S_BRANCH;
          OP_J:        w_next_state = S_JUMP;
          OP_ADDI:     w_next_state = S_ADDI_EXEC;
          default: begin
            w_illegal   = 1'b1;
            w_instr_end = 1'b1;
          end
        endcase
      end
      // IR is held stable, so the opcode still separates loads from stores here.
      S_MEM_ADDR:  w_next_state = (instr_opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) w_next_state = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) w_instr_end = 1'b1;
      S_EXECUTE:   w_next_state = S_ALU_WB;
      S_ADDI_EXEC: w_next_state = S_ADDI_WB;
      S_MEM_WB, S_ALU_WB, S_ADDI_WB, S_BRANCH, S_JUMP: w_instr_end = 1'b1;
      default:     w_next_state = S_IDLE;
    endcase
    if (w_instr_end) w_next_state = run ? S_FETCH : S_IDLE;
  end

  // State register; async clear abandons any in-flight instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Retirement counter, wraps naturally at the register width.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             r_retire_count <= '0;
    else if (w_instr_end) r_retire_count <= r_retire_count + {{(WORD_SIZE-1){1'b0}}, 1'b1};
  end

  // Datapath control decode from state; only FETCH's IR/PC loads wait on memory.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:    alu_src_b = 2'b11;
      S_MEM_ADDR, S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_ADDI_WB:   reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: ;
    endcase
  end

  assign illegal_op   = w_illegal;
  assign retired      = w_instr_end;
  assign retire_count = r_retire_count;
  assign state_dbg    = r_state;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style multi-cycle control sequencer for the MIPS-subset datapath, replacing the single-cycle `control_unit` when the datapath shares one memory port between fetch and data access. The block walks each instruction through fetch, decode, execute, memory and write-back states. It drives every datapath select, enable and ALU-op line, and stalls on a memory-ready handshake. It also counts retired instructions and flags illegal opcodes for the debug interface.

## Interface
- `WORD_SIZE`, default 32: width of `retire_count`.
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: reset, asynchronous and active-low.
- `run`, input, 1: sequencer enable, sampled in IDLE and at each instruction end.
- `instr_opcode`, input, 6: IR[31:26], held stable by the datapath IR from the end of FETCH to the end of the instruction.
- `mem_ready`, input, 1: memory access completes this cycle.
- `pc_write`, output, 1: unconditional PC load.
- `pc_write_cond`, output, 1: PC load when the ALU zero flag is set.
- `i_or_d`, output, 1: memory address source, 0=PC, 1=ALUOut.
- `mem_read`, output, 1: memory read request.
- `mem_write`, output, 1: memory write request.
- `ir_write`, output, 1: IR load enable.
- `mem_to_reg`, output, 1: register write data source, 1=MDR, 0=ALUOut.
- `reg_dst`, output, 1: destination register, 1=rd, 0=rt.
- `reg_write`, output, 1: register file write enable.
- `alu_src_a`, output, 1: ALU operand A, 0=PC, 1=rs data.
- `alu_src_b`, output, 2: ALU operand B, 00=rt data, 01=4, 10=sign-extended immediate, 11=sign-extended immediate shifted left 2.
- `alu_op`, output, 2: to `alu_control`, 00=add, 01=sub, 10=funct field.
- `pc_source`, output, 2: PC source, 00=ALU result, 01=ALUOut, 10=jump target.
- `illegal_op`, output, 1: one-cycle pulse on an undecodable opcode.
- `retired`, output, 1: one-cycle pulse when an instruction completes.
- `retire_count`, output, `WORD_SIZE`: number of retired instructions.
- `state_dbg`, output, 4: current state encoding.

## Operation
- State encodings:
  - IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5.
  - MEM_WRITE=6, EXECUTE=7, ALU_WB=8, BRANCH=9, JUMP=10, ADDI_EXEC=11, ADDI_WB=12.
  - Encodings 13–15 go to IDLE on the next clock.
- Outputs are decoded from the state register. The only exception is `ir_write` and `pc_write` in FETCH, which are ANDed with `mem_ready`. Any output not listed for a state is 0.
  - IDLE: no outputs asserted.
  - FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00, `ir_write`=`pc_write`=`mem_ready`.
  - DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (precomputes the branch target).
  - MEM_ADDR and ADDI_EXEC: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
  - MEM_READ: `mem_read`=1, `i_or_d`=1.
  - MEM_WRITE: `mem_write`=1, `i_or_d`=1.
  - MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0.
  - EXECUTE: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10.
  - ALU_WB: `reg_write`=1, `reg_dst`=1.
  - ADDI_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0.
  - BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01.
  - JUMP: `pc_write`=1, `pc_source`=10.
- Transitions:
  - IDLE→FETCH when `run`=1.
  - FETCH holds while `mem_ready`=0, then →DECODE.
  - DECODE dispatches on `instr_opcode`:
    - 0x00→EXECUTE, 0x23 or 0x2B→MEM_ADDR, 0x04→BRANCH, 0x02→JUMP, 0x08→ADDI_EXEC.
    - Any other opcode pulses `illegal_op` and is treated as an instruction end.
  - MEM_ADDR→MEM_READ for 0x23, →MEM_WRITE for 0x2B.
  - MEM_READ holds until `mem_ready`, then →MEM_WB.
  - MEM_WRITE holds until `mem_ready`, then ends the instruction.
  - EXECUTE→ALU_WB, ADDI_EXEC→ADDI_WB.
  - MEM_WB, ALU_WB, ADDI_WB, BRANCH and JUMP each end the instruction.
- Instruction end: next state is FETCH if `run`=1, else IDLE.
- `retired` pulses in the cycle of every instruction end, including an illegal opcode. `retire_count` increments by 1 on that clock edge and wraps modulo 2^`WORD_SIZE`.
- `run` deasserted mid-instruction does not abort the instruction. It is honoured only at the instruction end.

## Timing
- Reset (`rst`=0): the asynchronous clear forces state=IDLE and `retire_count`=0. All outputs are 0, including `state_dbg`.
- Release of reset is taken on the next rising edge.
- Latency with `mem_ready` tied to 1 (cycles from entering FETCH to `retired`):
  - JUMP and BRANCH: 3.
  - R-type, ADDI and SW: 4.
  - LW: 5.
  - Illegal opcode: 2.
- Each cycle `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. Request outputs stay asserted and stable throughout the stall.
- `mem_ready` is ignored in every other state.
- Reset asserted mid-instruction abandons it immediately: no `retired` pulse, and outputs are 0 in the same cycle.

## Test plan
- Reset, then `run`=1, `mem_ready`=1, opcode 0x00: `state_dbg` sequence 0,1,2,7,8,1. `reg_write`=`reg_dst`=1 in state 8. `retire_count`=1 after the ALU_WB edge.
- LW (0x23) with `mem_ready` held low for 3 cycles in MEM_READ: `mem_read`=`i_or_d`=1 for 4 cycles, then MEM_WB with `mem_to_reg`=1. Total 8 cycles from FETCH to `retired`.
- FETCH with `mem_ready`=0 for 2 cycles: `ir_write`=`pc_write`=0 for those 2 cycles, then 1 for exactly one cycle.
- Opcode 0x3F: `illegal_op` and `retired` pulse together in DECODE, next state FETCH, `retire_count` increments.
- `run` dropped in the EXECUTE cycle of an R-type: ALU_WB still completes, then the state goes to IDLE and stays there. Reasserting `run` restarts at FETCH.
- Preload `retire_count` near wrap (width-reduced `WORD_SIZE`=4, 15 retirements), retire once more: count reads 0. Assert `rst` mid-MEM_WRITE: all outputs go to 0 immediately and the state reads IDLE.
